keypad_event_scanner: RTL and testbench

//  Scans the 4x4 matrix keypad, debounces press and release, and emits one key event per

---
 rtl/keypad_event_scanner.sv | 146 ++++++++++++++
 tb/tb_keypad_event_scanner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_scanner.sv
// 4x4 matrix keypad scanner: drives one column at a time, debounces press and release,
// and emits a single-cycle key_valid strobe with the decoded key per physical press.
module keypad_event_scanner #(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] row_reg,
    output logic [3:0] col_reg
);

    localparam int unsigned SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [SW-1:0] SETTLE_LAST   = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DEBOUNCE_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_t;

    state_t        state_q;
    logic [3:0]    row_meta_q;
    logic [3:0]    rs_q;
    logic [3:0]    pattern_q;
    logic [1:0]    col_q;
    logic [1:0]    col_next;
    logic [SW-1:0] settle_q;
    logic [DW-1:0] deb_q;
    logic          single_low;

    assign col_next   = col_q + 2'd1;
    // Ghosting (two or more rows low) is deliberately treated the same as idle.
    assign single_low = (rs_q == 4'b1110) || (rs_q == 4'b1101) ||
                        (rs_q == 4'b1011) || (rs_q == 4'b0111);

    function automatic logic [3:0] key_lookup(input logic [3:0] pattern, input logic [1:0] col);
        logic [1:0] r;
        logic [3:0] code;
        case (pattern)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case ({r, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q <= 4'hF;
            rs_q       <= 4'hF;
            pattern_q  <= 4'hF;
            state_q    <= StScan;
            col_q      <= 2'd0;
            settle_q   <= '0;
            deb_q      <= '0;
            shift_col  <= 4'b1110;
            key_code   <= 4'h0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
            row_reg    <= 4'h0;
            col_reg    <= 4'h0;
        end else begin
            row_meta_q <= row;
            rs_q       <= row_meta_q;
            key_valid  <= 1'b0;
            unique case (state_q)
                StScan: begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_q <= '0;
                        if (single_low) begin
                            pattern_q <= rs_q;
                            deb_q     <= '0;
                            state_q   <= StDebounce;
                        end else begin
                            col_q     <= col_next;
                            shift_col <= ~(4'b0001 << col_next);
                        end
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                StDebounce: begin
                    if (rs_q != pattern_q) begin
                        state_q   <= StScan;
                        settle_q  <= '0;
                        col_q     <= col_next;
                        shift_col <= ~(4'b0001 << col_next);
                    end else if (deb_q == DEBOUNCE_LAST) begin
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        key_code  <= key_lookup(pattern_q, col_q);
                        row_reg   <= ~pattern_q;
                        col_reg   <= 4'b0001 << col_q;
                        state_q   <= StHeld;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                StHeld: begin
                    // Column stays frozen so the held key keeps pulling its row low.
                    if (rs_q == 4'hF) begin
                        deb_q   <= '0;
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    if (rs_q != 4'hF) begin
                        state_q <= StHeld;
                    end else if (deb_q == DEBOUNCE_LAST) begin
                        key_held  <= 1'b0;
                        state_q   <= StScan;
                        settle_q  <= '0;
                        col_q     <= col_next;
                        shift_col <= ~(4'b0001 << col_next);
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Bench for keypad_event_scanner: a simulated key matrix feeds the rows back from shift_col,
// and a behavioural keypad model is checked against the DUT outputs every cycle.
module tb_keypad_event_scanner;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned DEB    = 16;
    localparam int PH_SCAN = 0, PH_DEB = 1, PH_HELD = 2, PH_REL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  shift_col, key_code, row_reg, col_reg;
    logic        key_valid, key_held;
    logic [15:0] pressed;

    int tests  = 0;
    int fails  = 0;
    int pulses = 0;

    // Model: phase, column, samples counted in the current phase, sync pipe, captured rows.
    int         m_phase, m_col, m_t;
    logic [3:0] m_s1, m_rs, m_cap;
    logic [3:0] e_code, e_row, e_col;
    logic       e_valid, e_held;
    int unsigned keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_event_scanner #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row      (row),
        .shift_col(shift_col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held),
        .row_reg  (row_reg),
        .col_reg  (col_reg)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !shift_col[c]) row[r] = 1'b0;
    end

    task automatic model_reset();
        m_phase = PH_SCAN; m_col = 0; m_t = 0;
        m_s1 = 4'hF; m_rs = 4'hF; m_cap = 4'hF;
        e_code = 4'h0; e_row = 4'h0; e_col = 4'h0; e_valid = 1'b0; e_held = 1'b0;
    endtask

    // Advances the model by one clock using the row value the DUT will sample next edge.
    task automatic model_step();
        int r;
        e_valid = 1'b0;
        case (m_phase)
            PH_SCAN: begin
                if (m_t < int'(SETTLE) - 1) m_t++;
                else begin
                    m_t = 0;
                    if ($countones(~m_rs) == 1) begin m_cap = m_rs; m_phase = PH_DEB; end
                    else m_col = (m_col + 1) % 4;
                end
            end
            PH_DEB: begin
                if (m_rs != m_cap) begin
                    m_phase = PH_SCAN; m_t = 0; m_col = (m_col + 1) % 4;
                end else if (m_t < int'(DEB) - 1) m_t++;
                else begin
                    r = 0;
                    for (int i = 0; i < 4; i++) if (!m_cap[i]) r = i;
                    e_valid = 1'b1;
                    e_held  = 1'b1;
                    e_code  = 4'(keymap[r*4+m_col]);
                    e_row   = ~m_cap;
                    e_col   = 4'(1 << m_col);
                    m_phase = PH_HELD; m_t = 0;
                end
            end
            PH_HELD: if (m_rs == 4'hF) begin m_phase = PH_REL; m_t = 0; end
            default: begin
                if (m_rs != 4'hF) m_phase = PH_HELD;
                else if (m_t < int'(DEB) - 1) m_t++;
                else begin
                    e_held = 1'b0; m_phase = PH_SCAN; m_t = 0; m_col = (m_col + 1) % 4;
                end
            end
        endcase
        m_rs = m_s1;
        m_s1 = row;
    endtask

    task automatic compare_outputs();
        logic [3:0] exp_sc;
        exp_sc = ~(4'b0001 << m_col);
        tests++;
        if (shift_col !== exp_sc || key_code !== e_code || key_valid !== e_valid ||
            key_held !== e_held || row_reg !== e_row || col_reg !== e_col) begin
            fails++;
            $display("FAIL cycle_check @%0t: got sc=%b code=%h v=%b h=%b rr=%b cr=%b, want sc=%b code=%h v=%b h=%b rr=%b cr=%b",
                     $time, shift_col, key_code, key_valid, key_held, row_reg, col_reg,
                     exp_sc, e_code, e_valid, e_held, e_row, e_col);
        end
        if (key_valid === 1'b1) pulses++;
    endtask

    // One clock: compare on the falling edge, then return 2 time units after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!reset) model_reset();
        compare_outputs();
        if (reset) model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic check4(input string name, input logic [3:0] got, input logic [3:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic press(input int r, input int c);
        pressed = 16'b1 << (r * 4 + c);
    endtask

    task automatic release_all();
        int n;
        n = 0;
        pressed = '0;
        while (key_held !== 1'b0 && n < 200) begin tick(); n++; end
        check4("release_done", {3'b0, key_held}, 4'h0);
        run(8);
    endtask

    initial begin
        int p0;
        int n;
        logic [3:0] seen;
        reset   = 1'b1;
        pressed = '0;
        #1 reset = 1'b0;
        run(3);
        reset = 1'b1;
        check4("reset_shift_col", shift_col, 4'b1110);
        check4("reset_key_code", key_code, 4'h0);
        check4("reset_flags", {2'b0, key_valid, key_held}, 4'h0);
        check4("reset_row_reg", row_reg, 4'h0);
        check4("reset_col_reg", col_reg, 4'h0);

        // Idle rotation
        run(4); check4("rotate_col1", shift_col, 4'b1101);
        run(4); check4("rotate_col2", shift_col, 4'b1011);
        run(4); check4("rotate_col3", shift_col, 4'b0111);
        run(4); check4("rotate_wrap", shift_col, 4'b1110);
        p0 = pulses;
        run(184);
        check_int("idle_no_valid", pulses - p0, 0);

        // Key '5'
        p0 = pulses;
        press(1, 1);
        run(100);
        check_int("k5_one_valid", pulses - p0, 1);
        check4("k5_code", key_code, 4'h5);
        check4("k5_row_reg", row_reg, 4'b0010);
        check4("k5_col_reg", col_reg, 4'b0010);
        check4("k5_held", {3'b0, key_held}, 4'h1);
        release_all();
        check_int("k5_no_second", pulses - p0, 1);

        // Key '#' with press bounce
        p0 = pulses;
        repeat (5) begin press(3, 2); run(3); pressed = '0; run(3); end
        check_int("hash_bounce_rejected", pulses - p0, 0);
        press(3, 2);
        run(100);
        check_int("hash_one_valid", pulses - p0, 1);
        check4("hash_code", key_code, 4'hF);
        release_all();

        // Key 'A' with release bounce
        p0 = pulses;
        press(0, 3);
        run(100);
        check4("a_code", key_code, 4'hA);
        pressed = '0;
        run(4);
        for (int i = 0; i < 3; i++) begin
            press(0, 3); run(2); pressed = '0;
            if (i < 2) run(4);
        end
        check4("a_held_through_bounce", {3'b0, key_held}, 4'h1);
        n = 0;
        while (key_held === 1'b1 && n < 100) begin tick(); n++; end
        check_int("a_release_latency", n, int'(DEB) + 3);
        check_int("a_single_valid", pulses - p0, 1);
        run(8);

        // Ghost: rows 0 and 2 on col0
        p0 = pulses;
        seen = 4'h0;
        pressed = (16'b1 << 0) | (16'b1 << 8);
        repeat (100) begin tick(); seen = seen | ~shift_col; end
        check_int("ghost_no_valid", pulses - p0, 0);
        check4("ghost_scan_continues", seen, 4'hF);
        release_all();

        // Reset during debounce of '7'
        press(2, 0);
        n = 0;
        while (!(m_phase == PH_DEB && m_t >= 6) && n < 100) begin tick(); n++; end
        check4("k7_reached_debounce", {3'b0, (n < 100)}, 4'h1);
        p0 = pulses;
        reset = 1'b0;
        #1;
        check4("midreset_shift_col", shift_col, 4'b1110);
        check4("midreset_key_code", key_code, 4'h0);
        check4("midreset_flags", {2'b0, key_valid, key_held}, 4'h0);
        check4("midreset_regs", row_reg | col_reg, 4'h0);
        pressed = '0;
        run(3);
        reset = 1'b1;
        run(60);
        check_int("midreset_no_valid", pulses - p0, 0);
        press(2, 0);
        run(100);
        check_int("k7_fresh_valid", pulses - p0, 1);
        check4("k7_code", key_code, 4'h7);
        check4("k7_row_reg", row_reg, 4'b0100);
        check4("k7_col_reg", col_reg, 4'b0001);
        release_all();

        // Random presses, bounces and occasional second keys
        for (int i = 0; i < 40; i++) begin
            int k2;
            pressed = 16'b1 << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                k2 = int'($urandom_range(0, 15));
                pressed[k2] = 1'b1;
            end
            run(int'($urandom_range(1, 60)));
            pressed = '0;
            run(int'($urandom_range(1, 40)));
        end
        release_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
